// File: rtl/display_capture.sv
// Display-side receiver for the multiplexed 7-segment digit bus: debounces each
// select/value pair and demultiplexes accepted pairs into a parallel BCD array.
package digito_pkg;
    typedef logic [3:0] BCDnumber_t;
endpackage

module display_capture
    import digito_pkg::*;
#(
    parameter int NRO_DIGITOS   = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [5:0]                   in_digit_select,
    input  BCDnumber_t                   in_digit_number,
    output BCDnumber_t [NRO_DIGITOS-1:0] num,
    output logic [NRO_DIGITOS-1:0]       digit_valid,
    output logic                         frame_done,
    output logic                         err_sel,
    output logic                         err_bcd
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

    state_t                       state_reg, state_next;
    logic [5:0]                   prev_sel_reg;
    BCDnumber_t                   prev_num_reg;
    logic [CW-1:0]                cnt_reg, cnt_next;
    BCDnumber_t [NRO_DIGITOS-1:0] num_reg, num_next;
    logic [NRO_DIGITOS-1:0]       valid_reg, valid_next;
    logic [NRO_DIGITOS-1:0]       mask_reg, mask_next, mask_acc;
    logic                         frame_reg, frame_next;
    logic                         err_sel_reg, err_sel_next;
    logic                         err_bcd_reg, err_bcd_next;

    logic [NRO_DIGITOS-1:0]       legal_vec;
    logic                         legal, blank, same, reach;

    genvar gi;
    generate
        for (gi = 0; gi < NRO_DIGITOS; gi++) begin : g_decode
            assign legal_vec[gi] = (in_digit_select == ~(6'd1 << gi));
        end
    endgenerate

    assign legal = |legal_vec;
    assign blank = &in_digit_select;
    assign same  = (in_digit_select == prev_sel_reg) && (in_digit_number == prev_num_reg);
    // The edge on which the count would reach STABLE_CYCLES is the accept edge.
    assign reach = same && (cnt_reg == CW'(STABLE_CYCLES - 1));

    always_comb begin
        state_next   = state_reg;
        cnt_next     = CW'(1);
        num_next     = num_reg;
        valid_next   = valid_reg;
        mask_next    = mask_reg;
        mask_acc     = mask_reg | legal_vec;
        frame_next   = 1'b0;
        err_sel_next = 1'b0;
        err_bcd_next = 1'b0;

        if (same) begin
            cnt_next = (cnt_reg == CW'(STABLE_CYCLES)) ? cnt_reg : cnt_reg + CW'(1);
        end

        case (state_reg)
            IDLE, HELD: begin
                if (!same) state_next = DWELL;
            end
            DWELL: begin
                if (reach) begin
                    if (blank) begin
                        state_next = IDLE;
                    end else begin
                        state_next = HELD;
                        if (!legal) begin
                            err_sel_next = 1'b1;
                        end else if (in_digit_number > 4'd9) begin
                            err_bcd_next = 1'b1;
                        end else begin
                            for (int i = 0; i < NRO_DIGITOS; i++) begin
                                if (legal_vec[i]) num_next[i] = in_digit_number;
                            end
                            valid_next = valid_reg | legal_vec;
                            // The completing position starts the next frame empty.
                            if (&mask_acc) begin
                                frame_next = 1'b1;
                                mask_next  = '0;
                            end else begin
                                mask_next  = mask_acc;
                            end
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            prev_sel_reg <= 6'b11_1111;
            prev_num_reg <= '0;
            cnt_reg      <= '0;
            num_reg      <= '0;
            valid_reg    <= '0;
            mask_reg     <= '0;
            frame_reg    <= 1'b0;
            err_sel_reg  <= 1'b0;
            err_bcd_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prev_sel_reg <= in_digit_select;
            prev_num_reg <= in_digit_number;
            cnt_reg      <= cnt_next;
            num_reg      <= num_next;
            valid_reg    <= valid_next;
            mask_reg     <= mask_next;
            frame_reg    <= frame_next;
            err_sel_reg  <= err_sel_next;
            err_bcd_reg  <= err_bcd_next;
        end
    end

    assign num         = num_reg;
    assign digit_valid = valid_reg;
    assign frame_done  = frame_reg;
    assign err_sel     = err_sel_reg;
    assign err_bcd     = err_bcd_reg;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: debounce latency, frame pulses, error pulses, async reset.
`timescale 1ns/1ps
module tb_display_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  sel = 6'h3F;
    logic [3:0]  dnum = 4'd0;
    logic [15:0] num;
    logic [3:0]  digit_valid;
    logic        frame_done, err_sel, err_bcd;

    int checks = 0;
    int errors = 0;
    int n_fd = 0, n_es = 0, n_eb = 0;

    display_capture #(.NRO_DIGITOS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_digit_select(sel), .in_digit_number(dnum),
        .num(num), .digit_valid(digit_valid), .frame_done(frame_done),
        .err_sel(err_sel), .err_bcd(err_bcd)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_done) n_fd++;
        if (err_sel)    n_es++;
        if (err_bcd)    n_eb++;
    end

    // Apply a pair, then wait n rising edges and settle 1 ns past the last one.
    task automatic drive(input logic [5:0] s, input logic [3:0] v, input int n);
        sel  = s;
        dnum = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sel  = 6'h3F;
        dnum = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({num, digit_valid, frame_done, err_sel, err_bcd} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got num=%h valid=%b fd=%b es=%b eb=%b, want all zero",
                     num, digit_valid, frame_done, err_sel, err_bcd);
        end
        do_reset();
        $display("test_reset: num=%h valid=%b", num, digit_valid);
    endtask

    task automatic test_single();
        int b;
        do_reset();
        drive(6'h3E, 4'd3, 3);
        checks++;
        if (digit_valid !== 4'b0000) begin
            errors++; $display("FAIL single_early: valid=%b want 0000", digit_valid);
        end
        drive(6'h3E, 4'd3, 1);
        checks++;
        if (num !== 16'h0003 || digit_valid !== 4'b0001) begin
            errors++; $display("FAIL single_accept: num=%h valid=%b want 0003/0001", num, digit_valid);
        end
        b = n_fd + n_es + n_eb;
        drive(6'h3E, 4'd3, 10);
        checks++;
        if (n_fd + n_es + n_eb - b !== 0 || num !== 16'h0003 || digit_valid !== 4'b0001) begin
            errors++;
            $display("FAIL single_hold: pulses=%0d num=%h valid=%b want 0/0003/0001",
                     n_fd + n_es + n_eb - b, num, digit_valid);
        end
        $display("test_single: num=%h valid=%b", num, digit_valid);
    endtask

    task automatic test_frame();
        int bf;
        logic [3:0] v [2][4];
        logic [15:0] want [2];
        v[0] = '{4'd1, 4'd2, 4'd3, 4'd4};
        v[1] = '{4'd5, 4'd6, 4'd7, 4'd8};
        want[0] = 16'h4321;
        want[1] = 16'h8765;
        do_reset();
        bf = n_fd;
        for (int f = 0; f < 2; f++) begin
            drive(6'h3E, v[f][0], 4);
            drive(6'h3D, v[f][1], 4);
            drive(6'h3B, v[f][2], 4);
            drive(6'h37, v[f][3], 3);
            checks++;
            if (frame_done !== 1'b0 || n_fd - bf !== f) begin
                errors++;
                $display("FAIL frame_early%0d: fd=%b count=%0d want 0/%0d", f, frame_done, n_fd - bf, f);
            end
            drive(6'h37, v[f][3], 1);
            checks++;
            if (frame_done !== 1'b1 || num !== want[f] || digit_valid !== 4'hF) begin
                errors++;
                $display("FAIL frame_done%0d: fd=%b num=%h valid=%b want 1/%h/1111",
                         f, frame_done, num, digit_valid, want[f]);
            end
            drive(6'h37, v[f][3], 2);
            checks++;
            if (n_fd - bf !== f + 1) begin
                errors++; $display("FAIL frame_count%0d: got %0d want %0d", f, n_fd - bf, f + 1);
            end
            $display("test_frame %0d: num=%h pulses=%0d", f, num, n_fd - bf);
        end
    endtask

    task automatic test_glitch();
        int bs;
        do_reset();
        bs = n_es;
        drive(6'h3E, 4'd5, 4);
        drive(6'h3C, 4'd0, 2);
        drive(6'h3D, 4'd6, 6);
        checks++;
        if (n_es - bs !== 0 || num !== 16'h0065) begin
            errors++; $display("FAIL glitch_short: err_sel=%0d num=%h want 0/0065", n_es - bs, num);
        end
        drive(6'h3C, 4'd0, 3);
        checks++;
        if (err_sel !== 1'b0) begin
            errors++; $display("FAIL glitch_early: err_sel=%b want 0", err_sel);
        end
        drive(6'h3C, 4'd0, 1);
        checks++;
        if (err_sel !== 1'b1 || err_bcd !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL glitch_pulse: es=%b eb=%b fd=%b want 1/0/0", err_sel, err_bcd, frame_done);
        end
        drive(6'h3C, 4'd0, 4);
        checks++;
        if (n_es - bs !== 1 || num !== 16'h0065 || digit_valid !== 4'b0011) begin
            errors++;
            $display("FAIL glitch_hold: err_sel=%0d num=%h valid=%b want 1/0065/0011", n_es - bs, num, digit_valid);
        end
        $display("test_glitch: err_sel pulses=%0d num=%h", n_es - bs, num);
    endtask

    task automatic test_bad();
        int bs, bb;
        do_reset();
        bs = n_es;
        bb = n_eb;
        drive(6'h3D, 4'd12, 4);
        checks++;
        if (err_bcd !== 1'b1 || err_sel !== 1'b0) begin
            errors++; $display("FAIL bcd_pulse: eb=%b es=%b want 1/0", err_bcd, err_sel);
        end
        drive(6'h3D, 4'd12, 3);
        checks++;
        if (n_eb - bb !== 1 || num !== 16'h0000 || digit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bcd_hold: eb=%0d num=%h valid=%b want 1/0000/0000", n_eb - bb, num, digit_valid);
        end
        drive(6'h2F, 4'd0, 4);
        checks++;
        if (err_sel !== 1'b1 || err_bcd !== 1'b0) begin
            errors++; $display("FAIL highsel_pulse: es=%b eb=%b want 1/0", err_sel, err_bcd);
        end
        drive(6'h2F, 4'd0, 3);
        checks++;
        if (n_es - bs !== 1 || n_eb - bb !== 1 || num !== 16'h0000) begin
            errors++;
            $display("FAIL highsel_hold: es=%0d eb=%0d num=%h want 1/1/0000", n_es - bs, n_eb - bb, num);
        end
        $display("test_bad: err_bcd=%0d err_sel=%0d", n_eb - bb, n_es - bs);
    endtask

    task automatic test_reaccept();
        int bf;
        do_reset();
        bf = n_fd;
        drive(6'h3E, 4'd7, 4);
        drive(6'h3E, 4'd8, 4);
        checks++;
        if (num[3:0] !== 4'd8) begin
            errors++; $display("FAIL reaccept_value: num0=%0d want 8", num[3:0]);
        end
        drive(6'h3D, 4'd1, 4);
        drive(6'h3B, 4'd2, 4);
        drive(6'h37, 4'd3, 3);
        checks++;
        if (n_fd - bf !== 0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reaccept_early: fd count=%0d want 0", n_fd - bf);
        end
        drive(6'h37, 4'd3, 1);
        checks++;
        if (frame_done !== 1'b1 || num !== 16'h3218) begin
            errors++; $display("FAIL reaccept_frame: fd=%b num=%h want 1/3218", frame_done, num);
        end
        drive(6'h37, 4'd3, 2);
        checks++;
        if (n_fd - bf !== 1) begin
            errors++; $display("FAIL reaccept_count: got %0d want 1", n_fd - bf);
        end
        $display("test_reaccept: num=%h pulses=%0d", num, n_fd - bf);
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(6'h3D, 4'd5, 4);
        checks++;
        if (digit_valid !== 4'b0010 || num !== 16'h0050) begin
            errors++; $display("FAIL arst_pre: valid=%b num=%h want 0010/0050", digit_valid, num);
        end
        drive(6'h3E, 4'd9, 3);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (num !== 16'h0000 || digit_valid !== 4'b0000) begin
            errors++; $display("FAIL arst_immediate: num=%h valid=%b want 0000/0000", num, digit_valid);
        end
        #1 rst = 1'b0;
        drive(6'h3E, 4'd9, 3);
        checks++;
        if (digit_valid !== 4'b0000) begin
            errors++; $display("FAIL arst_partial: valid=%b want 0000", digit_valid);
        end
        drive(6'h3E, 4'd9, 1);
        checks++;
        if (digit_valid !== 4'b0001 || num !== 16'h0009) begin
            errors++; $display("FAIL arst_fresh: valid=%b num=%h want 0001/0009", digit_valid, num);
        end
        $display("test_async_reset: num=%h valid=%b", num, digit_valid);
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_glitch();
        test_bad();
        test_reaccept();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_capture.md
# display_capture

Receiving end of the multiplexed 7-segment digit bus driven by the digit selector. It samples the active-low one-hot digit select and the BCD digit value, waits until each select/value pair has been stable long enough to reject switching glitches, and demultiplexes the pairs back into a parallel `BCDnumber_t` array. It also flags frame completion and protocol errors. It sits at display-side boards and in self-check benches, the mirror image of the digit selector.

## Interface
- `NRO_DIGITOS`, 4, number of digit positions reconstructed (1..6).
- `STABLE_CYCLES`, 4, consecutive identical samples required before a pair is accepted (≥2).
- `clk` input 1, single clock; all state updates on its rising edge.
- `rst` input 1, asynchronous, active-high reset.
- `in_digit_select` input 6, active-low one-hot digit select; `6'b11_1111` = blank.
- `in_digit_number` input `BCDnumber_t` (4 bits, `digito_pkg`), digit value for the selected position.
- `num` output `BCDnumber_t [NRO_DIGITOS-1:0]`, last accepted value per position.
- `digit_valid` output NRO_DIGITOS, bit i set once position i has been accepted since reset.
- `frame_done` output 1, one-cycle pulse when every position has been accepted since the last pulse.
- `err_sel` output 1, one-cycle pulse on an accepted illegal select pattern.
- `err_bcd` output 1, one-cycle pulse on an accepted legal select carrying a value > 9.

## Operation
- **Pattern decode (combinational on inputs):**
  - BLANK: all ones.
  - LEGAL(i): exactly one zero, at bit i < NRO_DIGITOS.
  - ILLEGAL: anything else, including a single zero at bit ≥ NRO_DIGITOS or multiple zeros.
- **Stability tracking:**
  - Registers `prev_sel` and `prev_num` hold the previous sample.
  - Counter `cnt` has width `$clog2(STABLE_CYCLES+1)`.
  - Each edge: if the input pair equals prev, `cnt <= cnt+1`, saturating at STABLE_CYCLES. Otherwise `cnt <= 1`.
  - `prev` is loaded with the input pair on every edge.
- **FSM states:**
  - IDLE: tracking, nothing accepted for the current pair.
  - DWELL: pair changed, counting.
  - HELD: pair accepted, waiting for a change.
- **Transitions:**
  - IDLE/HELD → DWELL on any change of the pair.
  - DWELL → HELD on the edge where `cnt` reaches STABLE_CYCLES (accept event).
  - A BLANK pair reaching STABLE_CYCLES → IDLE with no accept side effects.
  - Exactly one accept per dwell. A held pair is never re-accepted.
- **Accept actions:**
  - LEGAL(i), value ≤ 9: `num[i]` <= value, `digit_valid[i]` <= 1, frame-mask bit i <= 1.
  - LEGAL(i), value > 9: `err_bcd` pulse. `num`, `digit_valid` and the mask are unchanged.
  - ILLEGAL: `err_sel` pulse. No other change.
- **Frame tracking:**
  - An internal mask of NRO_DIGITOS bits records positions accepted in the current frame.
  - When an accept makes the mask all ones, `frame_done` pulses on that same edge and the mask clears to 0. The completing bit is not carried into the next frame.
  - Re-accepting a position already in the mask overwrites `num[i]` and leaves the mask unchanged.
  - Order of positions is irrelevant.

## Timing
- **Reset values (immediate on `rst` assertion, independent of `clk`):**
  - All outputs: `num` = 0, `digit_valid` = 0, `frame_done` = 0, `err_sel` = 0, `err_bcd` = 0.
  - Internal: `cnt` = 0, `prev_sel` = `6'b11_1111`, `prev_num` = 0, mask = 0, state IDLE.
- **Reset mid-dwell:** discards the partial count. After release, the pair needs a full STABLE_CYCLES sampled edges.
- **Accept latency:** a pair first sampled at edge E1 and held is accepted at edge E(STABLE_CYCLES). With the default, `num`, `digit_valid`, `frame_done` and the error pulses are visible after E4.
- **Short pairs:** a pair held for fewer than STABLE_CYCLES edges is never accepted. This applies equally to errors, so transition glitches raise no flag.
- **Pulse widths:** `frame_done`, `err_sel` and `err_bcd` are exactly one cycle, registered, and never simultaneous with each other.
- **Data-only change:** a value change with the select unchanged counts as a new pair and restarts the count.

## Test plan
- Reset, then drive `6'b11_1110`/3 for 4 cycles → `num[0]`=3 and `digit_valid`=`4'b0001` after the 4th edge. Holding 10 more cycles produces no further accept.
- Cycle positions 0..3 with values 1,2,3,4, each held 4 cycles → one `frame_done` pulse on position 3's accept edge and `num`={4,3,2,1}. Repeat → second pulse one frame later.
- Glitch: `6'b11_1100` for 2 cycles between digits → no `err_sel`. Hold it 4 cycles → exactly one `err_sel` pulse and `num` unchanged.
- `6'b11_1101`/12 held 4 cycles → one `err_bcd` pulse, `num[1]` and `digit_valid[1]` unchanged. With NRO_DIGITOS=4, `6'b10_1111` held 4 cycles → one `err_sel` pulse.
- Re-accept position 0 mid-frame (positions 0, 0, 1, 2, 3) → `num[0]` takes the second value and `frame_done` pulses once, on position 3.
- Assert `rst` asynchronously after 3 stable cycles → outputs 0 immediately. After release, acceptance requires 4 fresh edges.
